// File: rtl/xil_bram_fifo_ctrl_1clk_pkg.sv
// Shared helpers for the single-clock BRAM FIFO controller: output-buffer
// depth derivation and pointer wrap for arbitrary (non power-of-two) depths.
package xil_bram_fifo_ctrl_1clk_pkg;

  // Output buffer holds every word that can be in flight plus two more so a
  // pop, a capture and a fresh issue can all land in the same cycle.
  function automatic int obd_of(input int rdl);
    return rdl + 2;
  endfunction

  // Increment with wrap from lim-1 back to 0.
  function automatic int wrap_inc(input int p, input int lim);
    return (p >= lim - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/xil_bram_fifo_ctrl_1clk_obuf.sv
// Small show-ahead register FIFO that absorbs the RAM read latency.
// The head word is presented combinationally whenever the buffer is occupied.
module xil_fifo_obuf_1clk
  import xil_bram_fifo_ctrl_1clk_pkg::*;
#(
  parameter int DAT = 18,
  parameter int OBD = 4,
  parameter int CW  = $clog2(OBD + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           push_i,
  input  logic [DAT-1:0] push_dat_i,
  input  logic           pop_i,
  output logic [DAT-1:0] head_o,
  output logic           vld_o,
  output logic [CW-1:0]  cnt_o
);
  localparam int PW = (OBD > 1) ? $clog2(OBD) : 1;

  logic [DAT-1:0] mem_q [OBD];
  logic [PW-1:0]  wp_q;
  logic [PW-1:0]  rp_q;
  logic [CW-1:0]  cnt_q;
  logic           push_ok;
  logic           pop_ok;

  assign push_ok = push_i & ~clr_i;
  assign pop_ok  = pop_i & ~clr_i & (cnt_q != '0);

  // Pointers and occupancy; a flush empties the buffer without touching storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= PW'(wrap_inc(32'(wp_q), OBD));
      if (pop_ok)  rp_q <= PW'(wrap_inc(32'(rp_q), OBD));
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage has no reset; only occupied slots are ever presented.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= push_dat_i;
  end

  assign head_o = mem_q[rp_q];
  assign vld_o  = (cnt_q != '0);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/xil_bram_fifo_ctrl_1clk.sv
// First-word-fall-through FIFO controller in front of a one-clock dual-port
// BRAM: port A writes, port B reads, and a credit-limited prefetch keeps a
// small output buffer topped up so the head word is always ready.
module xil_bram_fifo_ctrl_1clk
  import xil_bram_fifo_ctrl_1clk_pkg::*;
#(
  parameter int ADR = 10,
  parameter int DAT = 18,
  parameter int DEP = 1024,
  parameter int RDL = 2
) (
  input  logic           clka,
  input  logic           rsta,
  input  logic           clr,
  input  logic           wr_vld,
  input  logic [DAT-1:0] wr_dat,
  output logic           wr_full,
  output logic           rd_vld,
  output logic [DAT-1:0] rd_dat,
  input  logic           rd_rdy,
  output logic [ADR-1:0] ram_adra,
  output logic           ram_wena,
  output logic [DAT-1:0] ram_wdaa,
  output logic [ADR-1:0] ram_adrb,
  output logic           ram_renb,
  input  logic [DAT-1:0] ram_rdab,
  output logic [ADR+1:0] level,
  output logic           ovf_err
);
  localparam int OBD = obd_of(RDL);
  localparam int OCW = $clog2(OBD + 1);
  localparam int WCW = ADR + 1;
  localparam int LVW = ADR + 2;

  logic [ADR-1:0] wptr_q, wptr_d;
  logic [ADR-1:0] rptr_q, rptr_d;
  logic [ADR-1:0] adra_q, adra_d;
  logic [DAT-1:0] wdaa_q;
  logic           wena_q, wena_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [RDL-1:0] inf_q, inf_d;
  logic           ovf_q, ovf_d;

  logic           push_acc;
  logic           issue;
  logic           capture;
  logic           pop;
  logic [OCW-1:0] inf_cnt;
  logic [OCW-1:0] ob_cnt;
  logic [DAT-1:0] ob_head;
  logic           ob_vld;

  // The word being written this cycle still counts against capacity.
  assign wr_full  = ((wcnt_q + WCW'(wena_q)) == WCW'(DEP));
  assign push_acc = wr_vld & ~wr_full & ~clr;
  // Reads only target committed words, so port B never chases the write.
  assign issue    = (wcnt_q != '0) && ((inf_cnt + ob_cnt) < OCW'(OBD)) && !clr;
  assign capture  = inf_q[RDL-1] & ~clr;
  assign pop      = ob_vld & rd_rdy & ~clr;

  // Count reads currently travelling through the RAM read pipe.
  always_comb begin
    inf_cnt = '0;
    for (int i = 0; i < RDL; i++) inf_cnt = inf_cnt + OCW'(inf_q[i]);
  end

  // Next-state for pointers, occupancy, read pipe and overflow flag.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    adra_d = adra_q;
    wena_d = 1'b0;
    ovf_d  = ovf_q;
    inf_d  = (inf_q << 1) | RDL'(issue);
    wcnt_d = wcnt_q + WCW'(wena_q) - WCW'(issue);
    if (push_acc) begin
      wptr_d = ADR'(wrap_inc(32'(wptr_q), DEP));
      adra_d = wptr_q;
      wena_d = 1'b1;
    end
    if (issue) rptr_d = ADR'(wrap_inc(32'(rptr_q), DEP));
    if (wr_vld && wr_full) ovf_d = 1'b1;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      wcnt_d = '0;
      inf_d  = '0;
      ovf_d  = 1'b0;
      wena_d = 1'b0;
    end
  end

  // Control state register bank.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wptr_q <= '0;
      rptr_q <= '0;
      adra_q <= '0;
      wena_q <= 1'b0;
      wcnt_q <= '0;
      inf_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      adra_q <= adra_d;
      wena_q <= wena_d;
      wcnt_q <= wcnt_d;
      inf_q  <= inf_d;
      ovf_q  <= ovf_d;
    end
  end

  // Write-data register for RAM port A; masked at the output when idle.
  always_ff @(posedge clka) begin
    if (push_acc) wdaa_q <= wr_dat;
  end

  xil_fifo_obuf_1clk #(
    .DAT (DAT),
    .OBD (OBD),
    .CW  (OCW)
  ) u_obuf (
    .clk_i      (clka),
    .rst_i      (rsta),
    .clr_i      (clr),
    .push_i     (capture),
    .push_dat_i (ram_rdab),
    .pop_i      (pop),
    .head_o     (ob_head),
    .vld_o      (ob_vld),
    .cnt_o      (ob_cnt)
  );

  assign ram_adra = adra_q;
  assign ram_wena = wena_q;
  assign ram_wdaa = wena_q ? wdaa_q : '0;
  assign ram_adrb = rptr_q;
  assign ram_renb = issue;
  assign rd_vld   = ob_vld;
  assign rd_dat   = ob_vld ? ob_head : '0;
  assign ovf_err  = ovf_q;
  assign level    = LVW'(wcnt_q) + LVW'(wena_q) + LVW'(inf_cnt) + LVW'(ob_cnt);

endmodule

// File: tb/tb_xil_bram_fifo_ctrl_1clk.sv
// Directed bench for the BRAM FIFO controller: instance A uses the default
// 1024-deep configuration, instance B a 1000-deep one to exercise pointer wrap.
module tb_xil_bram_fifo_ctrl_1clk;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_clr = 0, a_wvld = 0, a_rrdy = 0;
  logic [17:0] a_wdat = '0;
  logic        a_full, a_rvld, a_wena, a_renb, a_ovf;
  logic [17:0] a_rdat, a_wdaa, a_rdab;
  logic [9:0]  a_adra, a_adrb;
  logic [11:0] a_level;

  // Instance B signals
  logic        b_clr = 0, b_wvld = 0, b_rrdy = 0;
  logic [17:0] b_wdat = '0;
  logic        b_full, b_rvld, b_wena, b_renb, b_ovf;
  logic [17:0] b_rdat, b_wdaa, b_rdab;
  logic [9:0]  b_adra, b_adrb;
  logic [11:0] b_level;

  xil_bram_fifo_ctrl_1clk #(.ADR(10), .DAT(18), .DEP(1024), .RDL(2)) u_a (
    .clka(clk), .rsta(rst), .clr(a_clr), .wr_vld(a_wvld), .wr_dat(a_wdat),
    .wr_full(a_full), .rd_vld(a_rvld), .rd_dat(a_rdat), .rd_rdy(a_rrdy),
    .ram_adra(a_adra), .ram_wena(a_wena), .ram_wdaa(a_wdaa), .ram_adrb(a_adrb),
    .ram_renb(a_renb), .ram_rdab(a_rdab), .level(a_level), .ovf_err(a_ovf));

  xil_bram_fifo_ctrl_1clk #(.ADR(10), .DAT(18), .DEP(1000), .RDL(2)) u_b (
    .clka(clk), .rsta(rst), .clr(b_clr), .wr_vld(b_wvld), .wr_dat(b_wdat),
    .wr_full(b_full), .rd_vld(b_rvld), .rd_dat(b_rdat), .rd_rdy(b_rrdy),
    .ram_adra(b_adra), .ram_wena(b_wena), .ram_wdaa(b_wdaa), .ram_adrb(b_adrb),
    .ram_renb(b_renb), .ram_rdab(b_rdab), .level(b_level), .ovf_err(b_ovf));

  // Two-cycle-latency RAM models
  logic [17:0] mem_a [1024];
  logic [17:0] mem_b [1024];
  logic [17:0] pa0, pa1, pb0, pb1;
  always @(posedge clk) begin
    if (a_wena) mem_a[a_adra] <= a_wdaa;
    if (a_renb) pa0 <= mem_a[a_adrb];
    pa1 <= pa0;
    if (b_wena) mem_b[b_adra] <= b_wdaa;
    if (b_renb) pb0 <= mem_b[b_adrb];
    pb1 <= pb0;
  end
  assign a_rdab = pa1;
  assign b_rdab = pb1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int   n_in, n_out, gaps, fullseen, last_c, full_at, quiet, maxa, collide;
  logic acc;

  initial begin
    // Reset state
    tick; tick;
    chk("rst_level", 32'(a_level), 0);
    chk("rst_rdvld", 32'(a_rvld), 0);
    chk("rst_rddat", 32'(a_rdat), 0);
    chk("rst_full",  32'(a_full), 0);
    chk("rst_wena",  32'(a_wena), 0);
    chk("rst_renb",  32'(a_renb), 0);
    chk("rst_wdaa",  32'(a_wdaa), 0);
    chk("rst_ovf",   32'(a_ovf), 0);
    rst = 1'b0;
    tick;

    // Single push of 0x2A5 and empty-FIFO latency
    a_wvld = 1; a_wdat = 18'h2A5;
    tick;                               // E0
    a_wvld = 0;
    chk("p1_wena_e0", 32'(a_wena), 1);
    chk("p1_adra_e0", 32'(a_adra), 0);
    chk("p1_wdaa_e0", 32'(a_wdaa), 32'h2A5);
    chk("p1_lvl_e0",  32'(a_level), 1);
    tick;                               // E1
    chk("p1_renb_e1", 32'(a_renb), 1);
    chk("p1_adrb_e1", 32'(a_adrb), 0);
    chk("p1_wena_e1", 32'(a_wena), 0);
    tick;                               // E2
    chk("p1_renb_e2", 32'(a_renb), 0);
    chk("p1_lvl_e2",  32'(a_level), 1);
    tick;                               // E3
    chk("p1_rvld_e3", 32'(a_rvld), 0);
    tick;                               // E4
    chk("p1_rvld_e4", 32'(a_rvld), 1);
    chk("p1_rdat_e4", 32'(a_rdat), 32'h2A5);
    chk("p1_lvl_e4",  32'(a_level), 1);
    a_rrdy = 1;
    tick;                               // E5 pop
    chk("p1_rvld_pop", 32'(a_rvld), 0);
    chk("p1_lvl_pop",  32'(a_level), 0);

    // Streaming 0..2047 with rd_rdy held high
    n_in = 0; n_out = 0; gaps = 0; fullseen = 0; last_c = 0;
    a_wvld = 1; a_wdat = 18'd0;
    for (int c = 0; c < 2200 && n_out < 2048; c++) begin
      if (a_rvld) begin
        chk("s3_data", 32'(a_rdat), 32'(n_out));
        n_out++;
        last_c = c;
      end else if (n_out > 0) gaps++;
      if (a_full) fullseen++;
      acc = a_wvld && !a_full;
      tick;
      if (acc) n_in++;
      a_wvld = (n_in < 2048);
      a_wdat = 18'(n_in);
    end
    a_wvld = 0;
    chk("s3_count", 32'(n_out), 2048);
    chk("s3_gaps",  32'(gaps), 0);
    chk("s3_full",  32'(fullseen), 0);
    chk("s3_last",  32'(last_c), 2052);

    // Fill with rd_rdy low: 1030 push attempts
    a_rrdy = 0; a_wvld = 1; n_in = 0; full_at = -1;
    for (int n = 0; n < 1030; n++) begin
      a_wdat = 18'(n);
      acc = !a_full;
      tick;
      if (acc) n_in++;
      if (a_full && full_at < 0) begin
        full_at = n_in;
        chk("s4_ovf_pre",  32'(a_ovf), 0);
        chk("s4_lvl_full", 32'(a_level), 1028);
      end
    end
    a_wvld = 0;
    tick; tick;
    chk("s4_accepted", 32'(n_in), 1028);
    chk("s4_full_at",  32'(full_at), 1028);
    chk("s4_ovf",      32'(a_ovf), 1);
    chk("s4_full",     32'(a_full), 1);
    chk("s4_level",    32'(a_level), 1028);
    chk("s4_renb",     32'(a_renb), 0);
    chk("s4_head",     32'(a_rdat), 0);

    // Drain
    a_rrdy = 1; n_out = 0;
    for (int c = 0; c < 1200 && n_out < 1028; c++) begin
      if (a_rvld) begin
        chk("s4_drain", 32'(a_rdat), 32'(n_out));
        n_out++;
      end
      tick;
    end
    chk("s4_drained",  32'(n_out), 1028);
    chk("s4_lvl_end",  32'(a_level), 0);
    chk("s4_full_end", 32'(a_full), 0);
    chk("s4_ovf_stk",  32'(a_ovf), 1);

    // Flush with two reads in flight and the buffer credit exhausted
    a_rrdy = 0; a_wvld = 1;
    for (int n = 0; n < 6; n++) begin
      a_wdat = 18'(32'h100 + n);
      tick;
    end
    chk("s5_lvl_pre",  32'(a_level), 6);
    chk("s5_renb_pre", 32'(a_renb), 0);
    chk("s5_head_pre", 32'(a_rdat), 32'h100);
    a_clr = 1; a_wdat = 18'h1FF; a_rrdy = 1;
    tick;
    a_clr = 0; a_wvld = 0;
    chk("s5_rvld", 32'(a_rvld), 0);
    chk("s5_lvl",  32'(a_level), 0);
    chk("s5_ovf",  32'(a_ovf), 0);
    chk("s5_wena", 32'(a_wena), 0);
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (a_rvld !== 1'b0 || a_level !== 12'd0) quiet++;
    end
    chk("s5_quiet", 32'(quiet), 0);
    a_wvld = 1; a_wdat = 18'h155;
    tick;
    a_wvld = 0;
    chk("s5_adra", 32'(a_adra), 0);
    tick;
    chk("s5_adrb", 32'(a_adrb), 0);
    tick; tick; tick;
    chk("s5_rvld2", 32'(a_rvld), 1);
    chk("s5_rdat2", 32'(a_rdat), 32'h155);
    tick;
    chk("s5_lvl2", 32'(a_level), 0);

    // Asynchronous reset mid-stream
    a_rrdy = 0; a_wvld = 1;
    for (int n = 0; n < 8; n++) begin
      a_wdat = 18'(32'h200 + n);
      tick;
    end
    chk("s6_lvl_pre",  32'(a_level), 8);
    chk("s6_rvld_pre", 32'(a_rvld), 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_level", 32'(a_level), 0);
    chk("s6_rvld",  32'(a_rvld), 0);
    chk("s6_rdat",  32'(a_rdat), 0);
    chk("s6_wena",  32'(a_wena), 0);
    chk("s6_wdaa",  32'(a_wdaa), 0);
    chk("s6_adra",  32'(a_adra), 0);
    chk("s6_adrb",  32'(a_adrb), 0);
    chk("s6_renb",  32'(a_renb), 0);
    a_wvld = 0;
    tick;
    rst = 1'b0;
    tick;
    a_wvld = 1; a_wdat = 18'h3C3;
    tick;                               // E0
    a_wvld = 0;
    chk("s6_wena_e0", 32'(a_wena), 1);
    tick; tick; tick;                   // E1..E3
    chk("s6_rvld_e3", 32'(a_rvld), 0);
    tick;                               // E4
    chk("s6_rvld_e4", 32'(a_rvld), 1);
    chk("s6_rdat_e4", 32'(a_rdat), 32'h3C3);

    // DEP=1000 instance: 3000 words with random rd_rdy
    n_in = 0; n_out = 0; maxa = 0; collide = 0;
    for (int c = 0; c < 20000 && n_out < 3000; c++) begin
      b_wvld = (n_in < 3000) && !b_full;
      b_wdat = 18'(n_in);
      b_rrdy = 1'($urandom_range(0, 1));
      if (b_rvld && b_rrdy) begin
        chk("s7_data", 32'(b_rdat), 32'(n_out));
        n_out++;
      end
      if (b_wena && 32'(b_adra) > maxa) maxa = 32'(b_adra);
      if (b_wena && b_renb && b_adra == b_adrb) collide++;
      acc = b_wvld;
      tick;
      if (acc) n_in++;
    end
    b_wvld = 0; b_rrdy = 0;
    chk("s7_count",   32'(n_out), 3000);
    chk("s7_maxadra", 32'(maxa), 999);
    chk("s7_collide", 32'(collide), 0);
    chk("s7_ovf",     32'(b_ovf), 0);
    chk("s7_level",   32'(b_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
